iq_sample_serializer: RTL and testbench
=======================================

# iq_sample_serializer

Transmit-side sample formatter for the spoofer datapath. It takes parallel I/Q sample pairs from the signal generator and emits one 16-bit word per transfer, interleaved I then Q, byte-swapped into the little-endian byte order of our recorded `gpssim.bin` captures. It sits between the baseband generator and the DAC/file-sink interface, and it is the inverse of the capture path that feeds `acquisition`. A small pair FIFO absorbs backpressure, and status outputs report throughput and starvation.

## Interface
Parameters:
- `SAMPLE_W`, 16, width of each I and Q sample; must be a multiple of 8.
- `FIFO_DEPTH`, 4, number of I/Q pairs buffered; must be a power of 2 and at least 2.
- `SWAP_BYTES`, 1, 1 = reverse the byte order of each output word; 0 = pass the word unchanged.

Ports:
- `clk`  in  1  sole clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  an I/Q pair is offered.
- `in_ready`  out  1  the block accepts a pair this cycle.
- `i_in`  in  SAMPLE_W  I sample, two's complement.
- `q_in`  in  SAMPLE_W  Q sample, two's complement.
- `out_valid`  out  1  `out_data` holds a valid word.
- `out_ready`  in  1  the sink accepts the word this cycle.
- `out_data`  out  SAMPLE_W  output word, formatted per `SWAP_BYTES`.
- `out_is_q`  out  1  0 = the current word is I; 1 = the current word is Q.
- `word_count`  out  32  number of accepted output words.
- `underrun`  out  1  sticky flag: the sink was starved after streaming started.

## Operation
- Input handshake:
  - A pair is pushed when `in_valid && in_ready`.
  - `in_ready = (count < FIFO_DEPTH)`, registered-count based.
  - A full FIFO deasserts `in_ready`, even if a pop happens in the same cycle (no pass-through).
- FIFO:
  - Storage is a circular buffer of {I,Q} pairs with `wr_ptr`/`rd_ptr` of log2(FIFO_DEPTH) bits. Both pointers wrap naturally.
  - `count` is log2(FIFO_DEPTH)+1 bits wide.
  - A simultaneous push and pop leaves `count` unchanged.
- Output phase FSM, with two states:
  - `PH_I`:
    - `out_data` = fmt(head.I) and `out_is_q` = 0.
    - On an output handshake, go to `PH_Q`.
  - `PH_Q`:
    - `out_data` = fmt(head.Q) and `out_is_q` = 1.
    - On an output handshake, pop the head pair and go to `PH_I`.
  - The FSM does not change state when there is no handshake.
- Output signals:
  - `out_valid = (count != 0)`.
  - An output handshake is `out_valid && out_ready`.
  - fmt(x): when `SWAP_BYTES`=1, the byte order is reversed (byte k ↔ byte SAMPLE_W/8-1-k); when it is 0, the word passes unchanged.
- Stability rule: while `out_valid && !out_ready`, `out_data` and `out_is_q` are held stable.
- `word_count` increments by 1 on each output handshake and wraps from 2^32-1 to 0.
- `underrun`:
  - An internal `started` bit sets on the first output handshake after reset.
  - `underrun` sets when `started && out_ready && !out_valid`.
  - Only `reset` clears `underrun`.
- Reset:
  - Reset has priority over every other event and may be asserted mid-pair.
  - The pointers, `count`, FSM (to `PH_I`), `word_count`, `started` and `underrun` all clear to 0.
  - Any half-emitted pair is discarded.
  - FIFO data storage is not reset.
- Reset values:
  - `in_ready`=1, `out_valid`=0, `out_is_q`=0, `word_count`=0, `underrun`=0.
  - `out_data` shows fmt(storage[0]); its value is don't-care while `out_valid`=0.

## Timing
- Latency:
  - A pair pushed at edge N into an empty FIFO gives `out_valid`=1 with the I word in the cycle after edge N.
  - The Q word follows after the I handshake; there is no combinational path from input to output.
- Throughput: one word per cycle with `out_ready` held high, which is one pair per 2 cycles. Input can therefore sustain 1/2 rate indefinitely.
- `in_ready` depends only on registered state; it has no combinational dependence on `out_ready`.
- `out_valid`, `out_is_q` and `out_data` are driven from registers/storage through the format mux only.
- Flags:
  - `underrun` asserts in the cycle after the starving edge condition and is registered.
  - `word_count` updates at the handshake edge.

## Structure
- Shared package `spoofer_pkg` holds:
  - the typedef `iq_pair_t` (packed struct {i, q}, SAMPLE_W each);
  - the phase enum `ser_phase_e {PH_I, PH_Q}`;
  - the function `byte_swap()`.
- Natural sub-module: `iq_pair_fifo`, a parameterized synchronous FIFO with a valid/ready interface and `count` output.
- The top level holds the phase FSM, the format mux, the counter and the flags.

## Test plan
- Reset release with `in_valid`=0 → `in_ready`=1, `out_valid`=0, `word_count`=0, `underrun`=0.
- Push I=16'h1234, Q=16'hABCD with `out_ready`=1 and `SWAP_BYTES`=1 → words 16'h3412 (`out_is_q`=0) then 16'hCDAB (`out_is_q`=1) on consecutive cycles; `word_count`=2.
- Push 4 pairs with `out_ready`=0 → `in_ready`=0 after the 4th push; the 5th offer is not accepted. Then raise `out_ready` → 8 words drain in order, and `in_ready` returns after the first pop.
- Stall mid-pair: drop `out_ready` during `PH_Q` for 3 cycles → `out_data` and `out_is_q` hold the Q word, with no pop and no count change.
- Stream 2 pairs, then stop input with `out_ready`=1 → `underrun`=1 one cycle after the FIFO empties; it stays set until reset.
- Assert `reset` after the I word of a pair → `out_valid`=0, the FSM returns to `PH_I`, and `word_count`=0. The next pushed pair starts with its I word.

Source files
------------

// File: rtl/spoofer_pkg.sv
// Shared types and helpers for the spoofer transmit datapath.
package spoofer_pkg;

  // Widest sample the byte-swap helper handles; narrower words are zero-extended.
  localparam int unsigned SW_MAX = 64;

  // Default-width I/Q pair as it appears on the generator side.
  localparam int unsigned IQ_W = 16;

  typedef struct packed {
    logic [IQ_W-1:0] i;
    logic [IQ_W-1:0] q;
  } iq_pair_t;

  typedef enum logic {
    PH_I = 1'b0,
    PH_Q = 1'b1
  } ser_phase_e;

  // Reverse the order of the low n_bytes bytes of x.
  function automatic logic [SW_MAX-1:0] byte_swap(input logic [SW_MAX-1:0] x,
                                                  input int unsigned     n_bytes);
    logic [SW_MAX-1:0] r;
    r = '0;
    for (int unsigned k = 0; k < SW_MAX / 8; k++) begin
      if (k < n_bytes) begin
        r[8*k +: 8] = x[8*(n_bytes-1-k) +: 8];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/iq_sample_serializer_if.sv
// I/Q pair input and serialized word output bundle.
interface iq_sample_serializer_if #(
  parameter int unsigned SAMPLE_W = 16
);
  logic                in_valid;
  logic                in_ready;
  logic [SAMPLE_W-1:0] i_in;
  logic [SAMPLE_W-1:0] q_in;
  logic                out_valid;
  logic                out_ready;
  logic [SAMPLE_W-1:0] out_data;
  logic                out_is_q;
  logic [31:0]         word_count;
  logic                underrun;

  modport master (
    output in_valid, i_in, q_in, out_ready,
    input  in_ready, out_valid, out_data, out_is_q, word_count, underrun
  );

  modport slave (
    input  in_valid, i_in, q_in, out_ready,
    output in_ready, out_valid, out_data, out_is_q, word_count, underrun
  );
endinterface

// File: rtl/iq_pair_fifo.sv
// Synchronous circular-buffer FIFO with valid/ready on both sides.
module iq_pair_fifo #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [W-1:0]               in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [W-1:0]               out_data,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          push;
  logic          pop;

  // Full blocks input even when a pop happens in the same cycle.
  assign in_ready  = (cnt < (AW+1)'(DEPTH));
  assign out_valid = (cnt != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = mem[rd_ptr];
  assign count     = cnt;

  // Storage write; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/iq_sample_serializer.sv
// Serializes buffered I/Q pairs into I-then-Q words with optional byte swap.
module iq_sample_serializer
  import spoofer_pkg::*;
#(
  parameter int unsigned SAMPLE_W   = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter bit          SWAP_BYTES = 1'b1
) (
  input logic                    clk,
  input logic                    reset,
  iq_sample_serializer_if.slave  bus
);
  logic [2*SAMPLE_W-1:0]        head;
  logic                         fifo_valid;
  logic                         pop_pair;
  logic                         out_hs;
  logic [$clog2(FIFO_DEPTH):0]  fifo_count;
  logic [SAMPLE_W-1:0]          raw_word;
  logic [SAMPLE_W-1:0]          fmt_word;
  ser_phase_e                   phase;
  ser_phase_e                   phase_nxt;
  logic                         started;
  logic                         underrun_q;
  logic [31:0]                  word_cnt;

  iq_pair_fifo #(
    .W     (2 * SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   ({bus.i_in, bus.q_in}),
    .out_valid (fifo_valid),
    .out_ready (pop_pair),
    .out_data  (head),
    .count     (fifo_count)
  );

  assign out_hs   = fifo_valid && bus.out_ready;
  assign pop_pair = out_hs && (phase == PH_Q);

  // Phase register.
  always_ff @(posedge clk) begin
    if (reset) phase <= PH_I;
    else       phase <= phase_nxt;
  end

  // Phase advances only on an output handshake.
  always_comb begin
    phase_nxt = phase;
    if (out_hs) begin
      phase_nxt = (phase == PH_I) ? PH_Q : PH_I;
    end
  end

  // Select the current half of the head pair and apply byte order.
  always_comb begin
    raw_word = (phase == PH_Q) ? head[SAMPLE_W-1:0] : head[2*SAMPLE_W-1:SAMPLE_W];
    fmt_word = raw_word;
    if (SWAP_BYTES) begin
      fmt_word = SAMPLE_W'(byte_swap(SW_MAX'(raw_word), SAMPLE_W / 8));
    end
  end

  // Throughput counter and sticky starvation flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_cnt   <= '0;
      started    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      if (out_hs) begin
        word_cnt <= word_cnt + 1'b1;
        started  <= 1'b1;
      end
      if (started && bus.out_ready && !fifo_valid) begin
        underrun_q <= 1'b1;
      end
    end
  end

  assign bus.out_valid  = fifo_valid;
  assign bus.out_data   = fmt_word;
  assign bus.out_is_q   = (phase == PH_Q);
  assign bus.word_count = word_cnt;
  assign bus.underrun   = underrun_q;
endmodule

// File: tb/tb_iq_sample_serializer.sv
// Directed bench for iq_sample_serializer with default parameters.
module tb_iq_sample_serializer;
  logic clk;
  logic reset;
  int unsigned n_checks;
  int unsigned n_pass;

  iq_sample_serializer_if #(.SAMPLE_W(16)) bus ();

  iq_sample_serializer #(
    .SAMPLE_W   (16),
    .FIFO_DEPTH (4),
    .SWAP_BYTES (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  // Advance past the next rising edge; inputs and checks happen 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] exp_i [4];
  logic [15:0] exp_q [4];
  logic [15:0] exp_w;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.i_in      = '0;
    bus.q_in      = '0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_wc",        bus.word_count,     32'd0);
    check("rst_underrun",  32'(bus.underrun),  32'd0);

    // Single pair, streaming sink
    bus.i_in = 16'h1234; bus.q_in = 16'hABCD;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("p1_valid", 32'(bus.out_valid), 32'd1);
    check("p1_i",     32'(bus.out_data),  32'h3412);
    check("p1_i_isq", 32'(bus.out_is_q),  32'd0);
    tick();
    check("p1_q",     32'(bus.out_data),  32'hCDAB);
    check("p1_q_isq", 32'(bus.out_is_q),  32'd1);
    tick();
    bus.out_ready = 1'b0;
    check("p1_wc",    bus.word_count,     32'd2);
    check("p1_empty", 32'(bus.out_valid), 32'd0);
    check("p1_nounder", 32'(bus.underrun), 32'd0);

    // Fill FIFO with sink stalled
    exp_i[0] = 16'hA001; exp_q[0] = 16'hB002;
    exp_i[1] = 16'hA101; exp_q[1] = 16'hB102;
    exp_i[2] = 16'hA201; exp_q[2] = 16'hB202;
    exp_i[3] = 16'hA301; exp_q[3] = 16'hB302;
    for (int k = 0; k < 4; k++) begin
      bus.i_in = exp_i[k]; bus.q_in = exp_q[k]; bus.in_valid = 1'b1;
      tick();
    end
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    bus.i_in = 16'hDEAD; bus.q_in = 16'hBEEF;
    tick();
    bus.in_valid = 1'b0;
    check("full_hold_ready", 32'(bus.in_ready), 32'd0);
    check("full_head",       32'(bus.out_data), 32'h01A0);

    // Drain eight words in order
    bus.out_ready = 1'b1;
    for (int w = 0; w < 8; w++) begin
      exp_w = (w % 2 == 0) ? exp_i[w/2] : exp_q[w/2];
      check("drain_valid", 32'(bus.out_valid), 32'd1);
      check("drain_data",  32'(bus.out_data),  32'({exp_w[7:0], exp_w[15:8]}));
      check("drain_isq",   32'(bus.out_is_q),  32'(w % 2));
      tick();
      if (w == 0) check("drain_ready_after_i", 32'(bus.in_ready), 32'd0);
      if (w == 1) check("drain_ready_after_pop", 32'(bus.in_ready), 32'd1);
    end
    bus.out_ready = 1'b0;
    check("drain_wc",    bus.word_count,     32'd10);
    check("drain_empty", 32'(bus.out_valid), 32'd0);

    // Stall during the Q phase
    bus.i_in = 16'h5566; bus.q_in = 16'h7788; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      check("stall_data",  32'(bus.out_data),  32'h8877);
      check("stall_isq",   32'(bus.out_is_q),  32'd1);
      check("stall_valid", 32'(bus.out_valid), 32'd1);
      check("stall_wc",    bus.word_count,     32'd11);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("stall_done_wc",    bus.word_count,     32'd12);
    check("stall_done_empty", 32'(bus.out_valid), 32'd0);

    // Starve the sink after streaming
    bus.i_in = 16'h0011; bus.q_in = 16'h0022; bus.in_valid = 1'b1;
    tick();
    bus.i_in = 16'h0033; bus.q_in = 16'h0044;
    tick();
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    check("ur_first", 32'(bus.out_data), 32'h1100);
    repeat (4) tick();
    check("ur_empty",   32'(bus.out_valid), 32'd0);
    check("ur_not_yet", 32'(bus.underrun),  32'd0);
    check("ur_wc",      bus.word_count,     32'd16);
    tick();
    check("ur_set", 32'(bus.underrun), 32'd1);
    bus.out_ready = 1'b0;
    repeat (3) tick();
    check("ur_sticky", 32'(bus.underrun), 32'd1);

    // Reset in the middle of a pair
    bus.i_in = 16'h0102; bus.q_in = 16'h0304; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("mid_isq", 32'(bus.out_is_q), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mr_valid",    32'(bus.out_valid), 32'd0);
    check("mr_isq",      32'(bus.out_is_q),  32'd0);
    check("mr_wc",       bus.word_count,     32'd0);
    check("mr_underrun", 32'(bus.underrun),  32'd0);
    check("mr_in_ready", 32'(bus.in_ready),  32'd1);
    bus.i_in = 16'hCAFE; bus.q_in = 16'hBEEF; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("mr_next_valid", 32'(bus.out_valid), 32'd1);
    check("mr_next_i",     32'(bus.out_data),  32'hFECA);
    check("mr_next_isq",   32'(bus.out_is_q),  32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
